jk_excitation_driver: RTL and testbench

//  Drives a JK flip-flop so that its Q follows a stream of target bits.

---
 rtl/jk_excitation_driver.sv | 111 +++++++++++
 tb/tb_jk_excitation_driver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// Drives a JK flop so its Q tracks a stream of target bits, checking Q feedback per transfer.
// Optional build macro JK_TOGGLE_PREF_EN: state-changing transitions are encoded as J=K=1.
module jk_excitation_driver #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic             j,
    output logic             k,
    input  logic             q_fb,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [1:0] {StIdle, StDrive, StCheck} state_e;

    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic             tgt_q, tgt_d;
    logic             q_exp_q, q_exp_d;
    logic             j_q, j_d;
    logic             k_q, k_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] done_cnt_q, done_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             enc_j, enc_k;

`ifdef JK_TOGGLE_PREF_EN
    assign enc_j = q_exp_q ^ tgt_bit;
    assign enc_k = q_exp_q ^ tgt_bit;
`else
    assign enc_j = ~q_exp_q & tgt_bit;
    assign enc_k = q_exp_q & ~tgt_bit;
`endif

    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        q_exp_d    = q_exp_q;
        j_d        = j_q;
        k_d        = k_q;
        err_d      = err_q;
        done_cnt_d = done_cnt_q;
        err_cnt_d  = err_cnt_q;
        tgt_ready  = 1'b0;
        unique case (state_q)
            StIdle: begin
                tgt_ready = 1'b1;
                if (tgt_valid) begin
                    tgt_d   = tgt_bit;
                    j_d     = enc_j;
                    k_d     = enc_k;
                    state_d = StDrive;
                end
            end
            StDrive: begin
                // The flop samples J/K at the edge leaving this state; release to hold after.
                j_d     = 1'b0;
                k_d     = 1'b0;
                state_d = StCheck;
            end
            StCheck: begin
                if (q_fb != tgt_q) begin
                    err_d = 1'b1;
                    if (err_cnt_q != CntMax) err_cnt_d = err_cnt_q + CNT_W'(1);
                end
                if (done_cnt_q != CntMax) done_cnt_d = done_cnt_q + CNT_W'(1);
                // Resync to what the flop actually holds so the next encode is correct.
                q_exp_d = q_fb;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tgt_q      <= 1'b0;
            q_exp_q    <= 1'b0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            err_q      <= 1'b0;
            done_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            q_exp_q    <= q_exp_d;
            j_q        <= j_d;
            k_q        <= k_d;
            err_q      <= err_d;
            done_cnt_q <= done_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign j        = j_q;
    assign k        = k_q;
    assign err      = err_q;
    assign busy     = (state_q != StIdle);
    assign done_cnt = done_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Scoreboard bench: two drivers (CNT_W=8 and CNT_W=2) each closing the loop through a JK flop model.
module tb_jk_excitation_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tgt_valid, tgt_bit, fault_act;
    logic       tgt_ready, j, k, busy, err;
    logic [7:0] done_cnt, err_cnt;
    logic       tgt_ready_s, j_s, k_s, busy_s, err_s;
    logic [1:0] done_cnt_s, err_cnt_s;
    logic       q_main, q_sat, q_fb_main;

    assign q_fb_main = fault_act ? 1'b0 : q_main;

    jk_excitation_driver #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready), .j(j), .k(k), .q_fb(q_fb_main), .busy(busy),
        .err(err), .done_cnt(done_cnt), .err_cnt(err_cnt)
    );

    jk_excitation_driver #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready_s), .j(j_s), .k(k_s), .q_fb(q_sat), .busy(busy_s),
        .err(err_s), .done_cnt(done_cnt_s), .err_cnt(err_cnt_s)
    );

    always_ff @(posedge clk) begin
        if (rst) q_main <= 1'b0;
        else case ({j, k})
            2'b01:   q_main <= 1'b0;
            2'b10:   q_main <= 1'b1;
            2'b11:   q_main <= ~q_main;
            default: q_main <= q_main;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) q_sat <= 1'b0;
        else case ({j_s, k_s})
            2'b01:   q_sat <= 1'b0;
            2'b10:   q_sat <= 1'b1;
            2'b11:   q_sat <= ~q_sat;
            default: q_sat <= q_sat;
        endcase
    end

    typedef struct packed {
        logic       abort;
        logic       t;
        logic       fault;
        logic       j;
        logic       k;
        logic       q;
        logic       err;
        logic [7:0] done;
        logic [7:0] ec;
        logic [1:0] sat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: busy rising marks DRIVE, busy falling marks the first IDLE cycle after a transfer.
    exp_t cur;
    logic have_cur  = 1'b0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (busy && !prev_busy) begin
            if (sb.size() == 0) begin
                chk("unexpected_transfer", 32'(sb.size()), 32'd1);
            end else begin
                cur      = sb.pop_front();
                have_cur = 1'b1;
                chk("drive_j", 32'(j), 32'(cur.j));
                chk("drive_k", 32'(k), 32'(cur.k));
                chk("drive_ready", 32'(tgt_ready), 32'd0);
            end
        end else if (!busy && prev_busy && have_cur) begin
            have_cur = 1'b0;
            if (!cur.abort) begin
                chk("idle_q", 32'(q_main), 32'(cur.q));
                chk("idle_err", 32'(err), 32'(cur.err));
                chk("idle_done_cnt", 32'(done_cnt), 32'(cur.done));
                chk("idle_err_cnt", 32'(err_cnt), 32'(cur.ec));
                chk("sat_done_cnt", 32'(done_cnt_s), 32'(cur.sat));
                chk("idle_jk", 32'({j, k}), 32'd0);
                chk("idle_ready", 32'(tgt_ready), 32'd1);
            end
        end
        prev_busy = busy;
    end

    task automatic wait_ready();
        int w = 0;
        while (!tgt_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        if (!tgt_ready) chk("ready_timeout", 32'(tgt_ready), 32'd1);
    endtask

    task automatic send(input logic t, input logic f, input logic ej, input logic ek,
                        input logic eq, input logic ee, input logic [7:0] ed,
                        input logic [7:0] eec, input logic [1:0] es);
        exp_t e;
        e = '{1'b0, t, f, ej, ek, eq, ee, ed, eec, es};
        sb.push_back(e);
        tgt_bit   = t;
        tgt_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        @(posedge clk); #1 fault_act = f;
        @(posedge clk); #1 fault_act = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        exp_t ab;
        tgt_valid = 1'b0;
        tgt_bit   = 1'b0;
        fault_act = 1'b0;
        do_reset();
        chk("rst_j", 32'(j), 32'd0);
        chk("rst_k", 32'(k), 32'd0);
        chk("rst_ready", 32'(tgt_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_done_cnt", 32'(done_cnt), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_q", 32'(q_main), 32'd0);

        //    t  f  j  k  q  e  done ec sat
`ifdef JK_TOGGLE_PREF_EN
        send(1, 0, 1, 1, 1, 0, 1, 0, 1);
        send(1, 0, 0, 0, 1, 0, 2, 0, 2);
        send(0, 0, 1, 1, 0, 0, 3, 0, 3);
        send(0, 0, 0, 0, 0, 0, 4, 0, 3);
        send(1, 0, 1, 1, 1, 0, 5, 0, 3);
        send(0, 0, 1, 1, 0, 0, 6, 0, 3);
        send(1, 1, 1, 1, 1, 1, 7, 1, 3);
        // Expected state resynced to 0 while the flop holds 1, so the toggle drops it to 0.
        send(1, 0, 1, 1, 0, 1, 8, 2, 3);
`else
        send(1, 0, 1, 0, 1, 0, 1, 0, 1);
        send(1, 0, 0, 0, 1, 0, 2, 0, 2);
        send(0, 0, 0, 1, 0, 0, 3, 0, 3);
        send(0, 0, 0, 0, 0, 0, 4, 0, 3);
        send(1, 0, 1, 0, 1, 0, 5, 0, 3);
        send(0, 0, 0, 1, 0, 0, 6, 0, 3);
        send(1, 1, 1, 0, 1, 1, 7, 1, 3);
        send(1, 0, 1, 0, 1, 1, 8, 1, 3);
`endif
        tgt_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Abort a transfer by asserting rst while it is in DRIVE.
        do_reset();
`ifdef JK_TOGGLE_PREF_EN
        ab = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0};
`else
        ab = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 2'd0};
`endif
        sb.push_back(ab);
        tgt_bit   = 1'b1;
        tgt_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        rst       = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(tgt_ready), 32'd1);
        chk("abort_jk", 32'({j, k}), 32'd0);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        chk("abort_err_cnt", 32'(err_cnt), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        chk("abort_q", 32'(q_main), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
